// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader and its receiver.
package boot_pkg;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] FULL_MASK  = 4'hF;
  // Value of the 2-bit byte-in-word counter when the final byte of a word arrives.
  localparam logic [1:0] LAST_BYTE  = 2'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } boot_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchronizes the line, samples mid-bit, rejects false
// starts, and reports frame errors. After a frame error it stays disarmed
// until the line returns high. CLKS_PER_BIT must be at least 8.
module uart_rx_8n1
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_frame_err
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       r_sync;
  logic             w_rx;
  rx_state_t        r_state;
  rx_state_t        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_wait_high;
  logic             r_byte_valid;
  logic             r_frame_err;
  logic             w_tick;

  assign w_rx = r_sync[1];

  // The sampling point: half a bit into the start bit, a full bit elsewhere.
  assign w_tick = (r_state == RX_START) ? (r_cnt == HALF_LAST) : (r_cnt == FULL_LAST);

  // Two-flop synchronizer, preset high so reset looks like an idle line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync <= 2'b11;
    end else begin
      // NOTE: non-blocking so each stage captures the pre-edge value of the one before it.
      r_sync <= {r_sync[0], i_rx};
    end
  end

  // Receiver state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= RX_IDLE;
    else        r_state <= w_state_next;
  end

  // Next receiver state from the sampled line and the bit timer.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    w_state_next = r_state;
    unique case (r_state)
      RX_IDLE:  if (!w_rx && !r_wait_high) w_state_next = RX_START;
      RX_START: if (w_tick) w_state_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick && (r_bit_idx == 3'd7)) w_state_next = RX_STOP;
      RX_STOP:  if (w_tick) w_state_next = RX_IDLE;
      default:  w_state_next = RX_IDLE;
    endcase
  end

  // Bit timer, data shift register, and the one-cycle result strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_wait_high  <= 1'b0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;

      if ((r_state == RX_IDLE) || w_tick) r_cnt <= '0;
      else                                 r_cnt <= r_cnt + CNT_W'(1);

      if (r_state == RX_START && w_tick) r_bit_idx <= '0;

      if (r_state == RX_DATA && w_tick) begin
        r_shift   <= {w_rx, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end

      if (r_state == RX_STOP && w_tick) begin
        if (w_rx) r_byte_valid <= 1'b1;
        else      r_frame_err  <= 1'b1;
      end

      // Re-arm only after the line has gone back to idle following a bad stop bit.
      if (r_state == RX_STOP && w_tick && !w_rx) r_wait_high <= 1'b1;
      else if (w_rx)                             r_wait_high <= 1'b0;
    end
  end

  assign o_byte_valid = r_byte_valid;
  assign o_byte_data  = r_shift;
  assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader: receives a length-prefixed little-endian image over UART and
// writes it word by word into BRAM, holding the CPU in reset until done.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          ADDR_W       = 22,
  parameter logic [31:0] BASE_WORD    = 32'd0,
  parameter logic [31:0] MAX_WORDS    = 32'd4194304
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_rx,
  output logic              mem_wen,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              cpu_hold,
  output logic              boot_done,
  output logic              err
);

  logic              w_byte_valid;
  logic [7:0]        w_byte_data;
  logic              w_frame_err;

  boot_state_t       r_state;
  boot_state_t       w_state_next;
  logic              r_hold_valid;
  logic [7:0]        r_hold_data;
  logic [1:0]        r_byte_cnt;
  logic [31:0]       r_asm;
  logic [31:0]       r_len;
  logic [31:0]       r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;

  logic              w_consume;
  logic              w_useful;
  logic              w_last_byte;
  logic [31:0]       w_asm_next;
  logic              w_overrun;
  logic              w_len_bad;
  logic              w_err_set;
  logic              w_err_any;
  logic              w_accept;

  uart_rx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock       (clock),
    .reset       (reset),
    .i_rx        (io_rx),
    .o_byte_valid(w_byte_valid),
    .o_byte_data (w_byte_data),
    .o_frame_err (w_frame_err)
  );

  // The holding register drains every cycle except while a write is pending;
  // in DONE and ERR the drained byte is simply discarded.
  assign w_consume   = r_hold_valid && (r_state != ST_WRITE);
  assign w_useful    = w_consume && ((r_state == ST_LEN) || (r_state == ST_DATA));
  assign w_last_byte = w_useful && (r_byte_cnt == LAST_BYTE);
  assign w_asm_next  = {r_hold_data, r_asm[31:8]};
  assign w_overrun   = w_byte_valid && r_hold_valid && !w_consume;
  assign w_len_bad   = (r_state == ST_LEN) && w_last_byte && (w_asm_next > MAX_WORDS);
  assign w_err_set   = w_frame_err || w_overrun || w_len_bad;
  assign w_err_any   = r_err || w_err_set;
  assign w_accept    = (r_state == ST_WRITE) && mem_ready;

  // Loader state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_LEN;
    else        r_state <= w_state_next;
  end

  // Loader sequencing; an error while a write is pending waits for the accept.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_LEN: begin
        if (w_err_any)                              w_state_next = ST_ERR;
        else if (w_last_byte && w_asm_next == '0)   w_state_next = ST_DONE;
        else if (w_last_byte)                       w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_err_any)        w_state_next = ST_ERR;
        else if (w_last_byte) w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (w_accept) begin
          if (w_err_any)                    w_state_next = ST_ERR;
          else if (r_idx + 32'd1 == r_len)  w_state_next = ST_DONE;
          else                              w_state_next = ST_DATA;
        end
      end
      ST_DONE, ST_ERR: w_state_next = r_state;
      default:         w_state_next = ST_ERR;
    endcase
  end

  // Holding register, byte assembly, write address/data, word index, sticky error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_byte_cnt   <= '0;
      r_asm        <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_consume) r_hold_valid <= 1'b0;
      if (w_byte_valid && (!r_hold_valid || w_consume)) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= w_byte_data;
      end

      if (w_useful) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_asm      <= w_asm_next;
      end

      if (w_last_byte && r_state == ST_LEN) r_len <= w_asm_next;

      if (w_last_byte && r_state == ST_DATA) begin
        r_wdata <= w_asm_next;
        r_addr  <= ADDR_W'(BASE_WORD + r_idx);
      end

      if (w_accept) r_idx <= r_idx + 32'd1;

      if (w_err_set) r_err <= 1'b1;
    end
  end

  // Outputs decoded from the loader state.
  always_comb begin
    mem_wen   = (r_state == ST_WRITE);
    mem_wmask = (r_state == ST_WRITE) ? FULL_MASK : 4'h0;
    cpu_hold  = (r_state != ST_DONE);
    boot_done = (r_state == ST_DONE);
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign err       = r_err;

endmodule
